// File: rtl/imx_ctrl_pkg.sv
// Shared constants for the IMX control datapath: reader FSM encoding and
// skid buffer depth.
package imx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int          SKID_DEPTH   = 2;
    localparam logic [1:0]  SKID_CREDITS = 2'(SKID_DEPTH);

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry buffer between the memory's registered read port and the stream
// output. The head entry drives the stream directly.
module axis_skid_fifo2
    import imx_ctrl_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_entry [SKID_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != 2'd0);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the two entries are reset too, so stale words never reach tdata after reset.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_entry[r_wr_ptr] <= i_push_data;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_entry[r_rd_ptr];
    assign o_full  = (r_count == SKID_CREDITS);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/bram_axis_reader.sv
// Reads a programmable run of words from a block memory's registered read
// port and streams them out as an AXI-Stream master with backpressure.
module bram_axis_reader
    import imx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [ADDRESS_WIDTH-1:0] i_base_addr,
    input  logic [ADDRESS_WIDTH:0]   i_count,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [ADDRESS_WIDTH-1:0] o_addrb,
    input  logic [DATA_WIDTH-1:0]    i_doutb,
    output logic                     o_axis_tvalid,
    input  logic                     i_axis_tready,
    output logic [DATA_WIDTH-1:0]    o_axis_tdata,
    output logic                     o_axis_tlast
);

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = (ADDRESS_WIDTH + 1)'(1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] r_last_addr;
    logic [ADDRESS_WIDTH:0]   r_remaining;
    logic                     r_inflight;
    logic                     r_inflight_last;
    logic                     r_done;

    logic                     w_issue;
    logic                     w_final_issue;
    logic                     w_start_run;
    logic                     w_start_zero;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [1:0]               w_fifo_count;
    logic [1:0]               w_credits_used;
    logic [DATA_WIDTH:0]      w_head;

    // The pop happening this cycle frees its slot, which keeps one beat per clock.
    assign w_pop          = !w_fifo_empty && i_axis_tready;
    assign w_push         = r_inflight && !w_fifo_full;
    assign w_credits_used = w_fifo_count + {1'b0, r_inflight} - {1'b0, w_pop};

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next  = r_state;
        w_issue       = 1'b0;
        w_final_issue = 1'b0;
        w_start_run   = 1'b0;
        w_start_zero  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_count != '0) begin
                        w_start_run  = 1'b1;
                        w_state_next = ST_READ;
                    end else begin
                        w_start_zero = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (w_credits_used < SKID_CREDITS) begin
                    w_issue = 1'b1;
                    if (r_remaining == CNT_ONE) begin
                        w_final_issue = 1'b1;
                        w_state_next  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_head[DATA_WIDTH]) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_last_addr     <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_final_issue;
            r_done          <= w_start_zero ||
                               ((r_state == ST_DRAIN) && (w_state_next == ST_IDLE));
            if (w_start_run) begin
                r_addr      <= i_base_addr;
                r_remaining <= i_count;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_ONE;
                r_last_addr <= r_addr;
                r_remaining <= r_remaining - CNT_ONE;
            end
        end
    end

    axis_skid_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({r_inflight_last, i_doutb}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // The address holds the last issued value whenever no read goes out.
    assign o_addrb       = w_issue ? r_addr : r_last_addr;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = r_done;
    assign o_axis_tvalid = !w_fifo_empty;
    assign o_axis_tdata  = w_head[DATA_WIDTH-1:0];
    assign o_axis_tlast  = w_head[DATA_WIDTH];

endmodule

// File: tb/tb_bram_axis_reader.sv
// Directed bench for bram_axis_reader with a registered-read memory model;
// beat data, tlast, stall stability and cycle timing are checked.
module tb_bram_axis_reader;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic [3:0] i_base_addr;
    logic [4:0] i_count;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_addrb;
    logic [7:0] i_doutb;
    logic       o_axis_tvalid;
    logic       i_axis_tready;
    logic [7:0] o_axis_tdata;
    logic       o_axis_tlast;

    logic [7:0] mem [16];
    int         edge_cnt;
    int         start_edge;
    int         n_checks;
    int         n_errors;

    bram_axis_reader #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_base_addr   (i_base_addr),
        .i_count       (i_count),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_addrb       (o_addrb),
        .i_doutb       (i_doutb),
        .o_axis_tvalid (o_axis_tvalid),
        .i_axis_tready (i_axis_tready),
        .o_axis_tdata  (o_axis_tdata),
        .o_axis_tlast  (o_axis_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        i_doutb  <= mem[o_addrb];
        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Leaves the bench at the negedge inside cycle N+1 (start sampled at edge N).
    task automatic start_run(input logic [3:0] base, input logic [4:0] count);
        @(negedge clk);
        i_start     = 1'b1;
        i_base_addr = base;
        i_count     = count;
        @(negedge clk);
        i_start    = 1'b0;
        start_edge = edge_cnt;
    endtask

    // mode 0: tready high, 1: tready toggles, 2: tready low 20 cycles, 3: steady + stray start
    task automatic run_check(input string tag, input logic [3:0] base, input logic [4:0] count,
                             input int mode);
        int         c;
        int         beats;
        int         first_beat;
        int         last_beat;
        int         done_cycle;
        int         done_pulses;
        bit         finished;
        logic       stalled;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [3:0] idx;
        beats = 0; first_beat = 0; last_beat = 0; done_cycle = 0; done_pulses = 0;
        finished = 1'b0; stalled = 1'b0; prev_data = '0; prev_last = 1'b0;
        start_run(base, count);
        while (!finished) begin
            c = edge_cnt - start_edge + 1;
            case (mode)
                1:       i_axis_tready = c[0];
                2:       i_axis_tready = (c > 20);
                default: i_axis_tready = 1'b1;
            endcase
            if (mode == 3) begin
                i_start     = (c == 3);
                i_base_addr = 4'd9;
                i_count     = 5'd3;
            end
            #1;
            if (c == 1) check({tag, " busy"}, o_busy, 1);
            if (mode == 2 && c == 1) check({tag, " first addr"}, o_addrb, base);
            if (mode == 2 && (c == 10 || c == 20)) check({tag, " frozen addr"}, o_addrb, base + 4'd1);
            if (o_axis_tvalid) begin
                if (stalled) begin
                    check({tag, " stable tdata"}, o_axis_tdata, prev_data);
                    check({tag, " stable tlast"}, o_axis_tlast, prev_last);
                end
                if (i_axis_tready) begin
                    idx = base + beats[3:0];
                    check({tag, " tdata"}, o_axis_tdata, mem[idx]);
                    check({tag, " tlast"}, o_axis_tlast, (beats == int'(count) - 1));
                    if (beats == 0) first_beat = c;
                    last_beat = c;
                    beats++;
                end
            end
            stalled   = o_axis_tvalid && !i_axis_tready;
            prev_data = o_axis_tdata;
            prev_last = o_axis_tlast;
            if (o_done) begin
                done_pulses++;
                if (done_cycle == 0) done_cycle = c;
            end
            if ((done_cycle != 0 && c == done_cycle + 1) || c >= 200) finished = 1'b1;
            else @(negedge clk);
        end
        check({tag, " done pulses"}, done_pulses, 1);
        check({tag, " beat count"}, beats, count);
        check({tag, " idle busy"}, o_busy, 0);
        check({tag, " idle tvalid"}, o_axis_tvalid, 0);
        if (mode == 0 || mode == 3) begin
            check({tag, " first beat cycle"}, first_beat, 3);
            check({tag, " last beat cycle"}, last_beat, 2 + int'(count));
            check({tag, " done cycle"}, done_cycle, 3 + int'(count));
        end
        if (mode == 2) begin
            check({tag, " last beat cycle"}, last_beat, 20 + int'(count));
            check({tag, " done cycle"}, done_cycle, 21 + int'(count));
        end
    endtask

    initial begin
        int done_pulses;
        int busy_seen;
        int valid_seen;
        n_checks = 0; n_errors = 0; edge_cnt = 0; start_edge = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_count = '0; i_axis_tready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("reset busy",   o_busy, 0);
        check("reset done",   o_done, 0);
        check("reset addrb",  o_addrb, 0);
        check("reset tvalid", o_axis_tvalid, 0);
        check("reset tdata",  o_axis_tdata, 0);
        check("reset tlast",  o_axis_tlast, 0);
        rst = 1'b0;

        run_check("basic", 4'd0, 5'd16, 0);
        run_check("wrap", 4'd14, 5'd4, 1);

        // Zero-length request: one done pulse, nothing else.
        i_axis_tready = 1'b1;
        start_run(4'd5, 5'd0);
        #1;
        check("zero done", o_done, 1);
        busy_seen = 0; valid_seen = 0; done_pulses = 0;
        repeat (6) begin
            if (o_busy) busy_seen++;
            if (o_axis_tvalid) valid_seen++;
            @(negedge clk);
            #1;
            if (o_done) done_pulses++;
        end
        check("zero busy", busy_seen, 0);
        check("zero tvalid", valid_seen, 0);
        check("zero extra done", done_pulses, 0);

        run_check("stall", 4'd3, 5'd8, 2);
        run_check("ignored start", 4'd2, 5'd6, 3);

        // Reset after three beats of a ten-word run.
        i_axis_tready = 1'b1;
        start_run(4'd0, 5'd10);
        for (int c = 1; c <= 5; c++) begin
            #1;
            if (c >= 3) check("pre-reset tdata", o_axis_tdata, mem[c - 3]);
            if (c < 5) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid reset busy",   o_busy, 0);
        check("mid reset done",   o_done, 0);
        check("mid reset addrb",  o_addrb, 0);
        check("mid reset tvalid", o_axis_tvalid, 0);
        check("mid reset tdata",  o_axis_tdata, 0);
        check("mid reset tlast",  o_axis_tlast, 0);
        rst = 1'b0;
        done_pulses = 0; valid_seen = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (o_done) done_pulses++;
            if (o_axis_tvalid) valid_seen++;
        end
        check("post reset done", done_pulses, 0);
        check("post reset tvalid", valid_seen, 0);

        run_check("after reset", 4'd5, 5'd10, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
